// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_pkg
//  Description : Shared constants, FSM state encoding and small helpers for
//                the spiking front end and the layer modules.
//                Contents: NUM_PIX, PIX_W, state_e, cnt_width().
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    localparam int NUM_PIX = 25;   // pixels per frame / spike lanes
    localparam int PIX_W   = 8;    // intensity bits per pixel

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width needed for a counter running 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : snn_pkg
`default_nettype wire

// File: rtl/spike_rate_cell.sv
`default_nettype none
// ============================================================================
//  Module      : spike_rate_cell
//  Description : One rate-coded spike lane. Holds a captured pixel intensity
//                and a phase accumulator; every step adds the intensity and
//                the carry out of the accumulator becomes the spike bit, so a
//                lane with intensity I spikes floor(n*I/2^PIX_W) times in n
//                steps.
//  Ports       : clk, reset (async, active low)
//                load      - capture intensity, clear accumulator and spike
//                step      - advance one timestep
//                clr       - force the spike output low (end / cancel)
//                intensity - pixel value to capture on load
//                spike     - registered spike bit, held between steps
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_rate_cell #(
    parameter int PIX_W = snn_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             clr,
    input  logic [PIX_W-1:0] intensity,
    output logic             spike
);

    logic [PIX_W-1:0] r_intensity;
    logic [PIX_W-1:0] r_acc;
    logic             r_spike;
    logic [PIX_W:0]   w_sum;

    // One extra bit so the wrap of the accumulator is visible as the carry.
    assign w_sum = {1'b0, r_acc} + {1'b0, r_intensity};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_intensity <= '0;
            r_acc       <= '0;
            r_spike     <= 1'b0;
        end else if (load) begin
            r_intensity <= intensity;
            r_acc       <= '0;
            r_spike     <= 1'b0;
        end else begin
            if (step) begin
                r_acc <= w_sum[PIX_W-1:0];
            end
            // clr wins so the lane reads zero in DONE and after a cancel.
            if (clr) begin
                r_spike <= 1'b0;
            end else if (step) begin
                r_spike <= w_sum[PIX_W];
            end
        end
    end

    assign spike = r_spike;

endmodule : spike_rate_cell
`default_nettype wire

// File: rtl/spike_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : spike_encoder
//  Description : Converts a frame of pixel intensities into NUM_STEPS rate-
//                coded spike vectors, one per timestep of STEP_DIV clocks.
//                Owns the IDLE/RUN/DONE FSM, the clock divider and the 16-bit
//                step counter; the per-pixel arithmetic lives in
//                spike_rate_cell.
//  Ports       : clk, reset (async, active low)
//                start     - frame request, honoured only in IDLE
//                abort     - synchronous cancel, has priority over start
//                pix_in    - NUM_PIX intensities, pixel i at [PIX_W*i +: PIX_W]
//                pixel_spk - spike vector of the current timestep
//                pulse     - one-cycle timestep strobe
//                busy      - state is not IDLE
//                done      - one-cycle end-of-frame strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_encoder #(
    parameter int NUM_PIX   = snn_pkg::NUM_PIX,
    parameter int PIX_W     = snn_pkg::PIX_W,
    parameter int NUM_STEPS = 64,
    parameter int STEP_DIV  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NUM_PIX*PIX_W-1:0] pix_in,
    output logic [NUM_PIX-1:0]       pixel_spk,
    output logic                     pulse,
    output logic                     busy,
    output logic                     done
);

    import snn_pkg::state_e;
    import snn_pkg::ST_IDLE;
    import snn_pkg::ST_RUN;
    import snn_pkg::ST_DONE;
    import snn_pkg::cnt_width;

    localparam int               c_div_w     = cnt_width(STEP_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(STEP_DIV - 1);
    localparam logic [15:0]      c_num_steps = 16'(NUM_STEPS);

    state_e             r_state;
    logic [c_div_w-1:0] r_div;
    logic [15:0]        r_step_cnt;
    logic               r_pulse;
    logic               r_done;

    logic w_load;
    logic w_step;
    logic w_clr;
    logic w_frame_end;

    assign w_frame_end = (r_step_cnt == c_num_steps);
    assign w_load      = (r_state == ST_IDLE) && start && !abort;
    // The last step leaves the counter at NUM_STEPS, which blocks any further
    // step even though the divider keeps wrapping (matters for STEP_DIV=1).
    assign w_step      = (r_state == ST_RUN) && !abort && (r_div == c_div_last)
                         && !w_frame_end;
    assign w_clr       = (r_state == ST_RUN) && (abort || w_frame_end);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_step_cnt <= '0;
            r_pulse    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_pulse <= w_step;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state    <= ST_RUN;
                        r_div      <= '0;
                        r_step_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_frame_end) begin
                        // Runs on the cycle after the final pulse.
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_div <= (r_div == c_div_last) ? '0 : r_div + 1'b1;
                        if (w_step) begin
                            r_step_cnt <= r_step_cnt + 16'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar i = 0; i < NUM_PIX; i++) begin : g_cell
            spike_rate_cell #(
                .PIX_W (PIX_W)
            ) u_cell (
                .clk       (clk),
                .reset     (reset),
                .load      (w_load),
                .step      (w_step),
                .clr       (w_clr),
                .intensity (pix_in[PIX_W*i +: PIX_W]),
                .spike     (pixel_spk[i])
            );
        end
    endgenerate

    assign pulse = r_pulse;
    assign done  = r_done;
    assign busy  = (r_state != ST_IDLE);

endmodule : spike_encoder
`default_nettype wire

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 SHALL have parameter NUM_PIX, default 25, number of input pixels and spike lanes.
REQ-002 SHALL have parameter PIX_W, default 8, intensity width per pixel.
REQ-003 SHALL have parameter NUM_STEPS, default 64, legal range 1..65535, number of timesteps per frame.
REQ-004 SHALL have parameter STEP_DIV, default 4, legal range >=1, clock cycles per timestep.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, frame request, honoured only in IDLE.
REQ-008 SHALL have port abort, input, 1, synchronous cancel of the current frame.
REQ-009 SHALL have port pix_in, input, NUM_PIX*PIX_W, pixel intensities, pixel i at bits [PIX_W*(i+1)-1 : PIX_W*i].
REQ-010 SHALL have port pixel_spk, output, NUM_PIX, spike vector for the current timestep, driving a layer's pixel input.
REQ-011 SHALL have port pulse, output, 1, one-cycle timestep strobe, driving a layer's pulse input.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle end-of-frame strobe.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE.
REQ-015 SHALL, on start=1 in IDLE with abort=0, capture pix_in, clear all accumulators, the divider and the step counter, and enter RUN at that edge.
REQ-016 SHALL ignore start outside IDLE and SHALL NOT recapture pix_in mid-frame.
REQ-017 SHALL, in RUN, run a divider 0..STEP_DIV-1 and fire a timestep on the edge where the divider wraps.
REQ-018 SHALL compute, at each timestep and for each pixel, sum = acc + intensity at PIX_W+1 bits, with spike bit = sum[PIX_W] and acc <= sum[PIX_W-1:0].
REQ-019 SHALL register pixel_spk and pulse on the same edge and hold pixel_spk stable until the next timestep.
REQ-020 SHALL make pulse high for exactly one cycle per timestep, with the first pulse exactly STEP_DIV cycles after the start-accept edge.
REQ-021 SHALL produce exactly NUM_STEPS pulses per frame, and pixel i SHALL spike exactly floor(NUM_STEPS*I/2^PIX_W) times.
REQ-022 SHALL, after the final pulse cycle, enter DONE for one cycle with done=1 and pixel_spk=0, then return to IDLE.
REQ-023 SHALL, when STEP_DIV=1, assert pulse on NUM_STEPS consecutive cycles.
REQ-024 SHALL, on abort=1 in RUN or DONE, return to IDLE at the next edge with pixel_spk=0, pulse=0 and done=0.
REQ-025 SHALL, when abort and start are both 1 in IDLE, give abort priority so that the frame does not start.
REQ-026 SHALL never produce a spike for intensity 0.
REQ-027 SHALL never produce a spike on a cycle where pulse=0.

Reset
REQ-028 SHALL, on reset=0, immediately force state=IDLE and pixel_spk=0, pulse=0, busy=0, done=0.
REQ-029 SHALL, on reset=0, clear all accumulators, intensity registers and counters, independent of clk.
REQ-030 SHALL, after reset assertion mid-frame, stay in IDLE until a new start and SHALL NOT assert done.

Structure
REQ-031 SHALL define NUM_PIX, PIX_W and the state encoding in the shared package snn_pkg, also used by the layer modules.
REQ-032 SHALL implement the per-pixel intensity register, accumulator and carry in sub-module spike_rate_cell.
REQ-033 SHALL instantiate NUM_PIX copies of spike_rate_cell in a generate loop, with common clk, reset, load and step enables.
REQ-034 SHALL keep the FSM, the divider and the 16-bit step counter in spike_encoder.

Verification
REQ-035 SHALL check: NUM_STEPS=64, STEP_DIV=4, all pixels=0x80 -> 64 pulses spaced 4 cycles apart; each lane spikes on even steps only, 32 spikes; done on the cycle after the 64th pulse.
REQ-036 SHALL check: pixels 0x00, 0x40, 0xFF, 0x01 on lanes 0..3 -> spike counts 0, 16, 63, 0; lane 1 spikes at steps 4, 8, ..., 64.
REQ-037 SHALL check: STEP_DIV=1, NUM_STEPS=8, pixel 0xC0 -> 8 consecutive pulses and 6 spikes at steps 2, 3, 4, 6, 7, 8.
REQ-038 SHALL check: start reasserted with a different pix_in during RUN -> counts unchanged, still exactly NUM_STEPS pulses.
REQ-039 SHALL check: abort at step 10 -> no further pulses, no done, busy low next cycle; a new start then produces a full, correct frame.
REQ-040 SHALL check: reset low mid-step, asynchronous to clk -> all outputs 0 within the same cycle; start plus abort together in IDLE -> busy stays 0.
